// File: rtl/mram_readout_sequencer_pkg.sv
// Shared definitions for the MRAM readout sequencer: FSM state encoding and
// default geometry/timeout constants used by the sequencer and its wrapper.
package mram_readout_sequencer_pkg;

  localparam int unsigned DEFAULT_ADDR_W  = 10;
  localparam int unsigned DEFAULT_WORD_W  = 16;
  localparam int unsigned DEFAULT_TIMEOUT = 255;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_LOAD  = 3'd3,
    ST_SHIFT = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/mram_readout_sequencer.sv
// MRAM readout sequencer: reads word_count words starting at base_addr from
// the MRAM and steers the parallel-in/serial-out serializer so that each word
// leaves MSB first.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   start           one-cycle pulse, accepted only when idle (abort wins)
//   abort           level, returns to idle from any active state
//   base_addr       first word address, sampled on accepted start
//   word_count      number of words, sampled on accepted start
//   mram_rd_req     one-cycle read strobe, mram_addr valid alongside
//   mram_rd_valid   read data present on the serializer input
//   ser_en          serializer enable (any non-idle state)
//   ser_load        serializer parallel load
//   ser_send        serializer shift strobe
//   tx_valid        serializer data_out carries a valid bit this cycle
//   busy            readout in progress
//   done            one-cycle pulse on normal completion
//   err             sticky read timeout, cleared by the next accepted start
module mram_readout_sequencer
  import mram_readout_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEFAULT_ADDR_W,
  parameter int unsigned WORD_W  = DEFAULT_WORD_W,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] word_count,
  output logic              mram_rd_req,
  output logic [ADDR_W-1:0] mram_addr,
  input  logic              mram_rd_valid,
  output logic              ser_en,
  output logic              ser_load,
  output logic              ser_send,
  output logic              tx_valid,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned BIT_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WORD_W - 1);
  // WAIT is left after TIMEOUT cycles, i.e. on the cycle the counter reads TIMEOUT-1
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_t              state;
  logic [ADDR_W-1:0]   addr_reg;
  logic [ADDR_W-1:0]   words_left;
  logic [BIT_W-1:0]    bit_cnt;
  logic [WAIT_W-1:0]   wait_cnt;

  // Address register is itself a flop; it only changes between words.
  assign mram_addr = addr_reg;

  // Sequencer FSM; every output is assigned for the state being entered so
  // it is high exactly while the FSM sits in the matching state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      addr_reg    <= '0;
      words_left  <= '0;
      bit_cnt     <= '0;
      wait_cnt    <= '0;
      mram_rd_req <= 1'b0;
      ser_en      <= 1'b0;
      ser_load    <= 1'b0;
      ser_send    <= 1'b0;
      tx_valid    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      mram_rd_req <= 1'b0;
      ser_load    <= 1'b0;
      ser_send    <= 1'b0;
      done        <= 1'b0;
      // Serializer data_out is registered, so its valid flag trails ser_send;
      // an abort drops the bit still in flight.
      tx_valid    <= ser_send && !abort;

      if (abort && (state != ST_IDLE)) begin
        state  <= ST_IDLE;
        busy   <= 1'b0;
        ser_en <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start && !abort) begin
              err        <= 1'b0;
              addr_reg   <= base_addr;
              words_left <= word_count;
              busy       <= 1'b1;
              ser_en     <= 1'b1;
              if (word_count == '0) begin
                state <= ST_DONE;
                done  <= 1'b1;
              end else begin
                state       <= ST_REQ;
                mram_rd_req <= 1'b1;
              end
            end
          end

          ST_REQ: begin
            state    <= ST_WAIT;
            wait_cnt <= '0;
          end

          ST_WAIT: begin
            if (mram_rd_valid) begin
              state    <= ST_LOAD;
              ser_load <= 1'b1;
            end else if (wait_cnt == WAIT_LAST) begin
              state  <= ST_IDLE;
              err    <= 1'b1;
              busy   <= 1'b0;
              ser_en <= 1'b0;
            end else begin
              wait_cnt <= wait_cnt + WAIT_W'(1);
            end
          end

          ST_LOAD: begin
            state    <= ST_SHIFT;
            bit_cnt  <= '0;
            ser_send <= 1'b1;
          end

          ST_SHIFT: begin
            if (bit_cnt == BIT_LAST) begin
              words_left <= words_left - ADDR_W'(1);
              addr_reg   <= addr_reg + ADDR_W'(1);
              if (words_left > ADDR_W'(1)) begin
                state       <= ST_REQ;
                mram_rd_req <= 1'b1;
              end else begin
                state <= ST_DONE;
                done  <= 1'b1;
              end
            end else begin
              bit_cnt  <= bit_cnt + BIT_W'(1);
              ser_send <= 1'b1;
            end
          end

          ST_DONE: begin
            state  <= ST_IDLE;
            busy   <= 1'b0;
            ser_en <= 1'b0;
          end

          default: begin
            state  <= ST_IDLE;
            busy   <= 1'b0;
            ser_en <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
